atm_bank_core: RTL and testbench
================================

// Module: atm_bank_core
// PURPOSE
//  Parametrised successor of the single-account ATM datapath. Accepts deposit/withdraw
//  button presses with a one-hot bill selection and keeps a BAL_W-bit balance. Rejects
//  overflow, insufficient funds and daily-withdrawal-limit violations with sticky flags.
//  Converts the balance to BCD (multi-cycle) and multiplexes NUM_DIGITS 7-seg digits.
//  Buttons arrive already debounced and synchronised.
// PARAMETERS
//  BAL_W        8    balance width; the balance spans 0..2^BAL_W-1. Requires BAL_W>=7.
//  NUM_DIGITS   3    display digits. Requires 10^NUM_DIGITS > 2^BAL_W-1.
//  WD_LIMIT     200  maximum cumulative withdrawal between day_clr pulses. Must fit in BAL_W+1 bits.
//  REFRESH_DIV  1000 clk cycles per digit in the display scan. Must be >=1.
// PORTS
//  clk       in   1             system clock
//  reset     in   1             synchronous, active-low reset
//  up_btn    in   1             deposit request (level; rising edge acts)
//  down_btn  in   1             withdraw request (level; rising edge acts)
//  day_clr   in   1             1-cycle pulse; clears the withdrawal total
//  sw        in   6             bill select: [0]$1 [1]$5 [2]$10 [3]$20 [4]$50 [5]$100
//  balance   out  BAL_W         current balance
//  busy      out  1             1 while in EXEC or CONV
//  led       out  4             [0] bad request [1] overflow [2] insufficient funds [3] limit reached
//  an        out  NUM_DIGITS    digit enables, active-low, one-hot-low
//  seg       out  7             segments g..a (seg[6]=g), active-low
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): all of the following are cleared or set together.
//   - balance=0, wd_total=0, led=0, FSM=IDLE, busy=0.
//   - BCD display register=0, edge registers=0, scan index=0, refresh counter=0.
//   - Result: an=~1 (digit0 on), seg=7'b1000000 ("0").
//  Edge detect: up_p = up_btn & ~up_q; down_p likewise. Pulses arriving outside IDLE are dropped.
//  Bill value: exactly one sw bit set gives the table value. Zero or several bits set is invalid.
//  FSM:
//   IDLE: on exactly one of up_p/down_p:
//    - Clear led[3:0] and latch op and bill.
//    - If the bill is invalid: set led[0] and stay in IDLE.
//    - Otherwise go to EXEC.
//    - up_p and down_p in the same cycle: set led[0] (after clearing) and stay in IDLE.
//   EXEC (1 cycle) for a deposit:
//    - If bal+bill > 2^BAL_W-1: set led[1], balance unchanged.
//    - Else balance += bill.
//   EXEC (1 cycle) for a withdraw, checked in this order:
//    - bill > bal: set led[2].
//    - wd_total+bill > WD_LIMIT: set led[3].
//    - Otherwise: balance -= bill and wd_total += bill.
//    - In both failing cases balance and wd_total are unchanged.
//   EXEC -> CONV always, including after a rejected transaction.
//   CONV: shift-add-3 binary-to-BCD on a snapshot of balance.
//    - Runs exactly BAL_W cycles.
//    - The display register loads on the last CONV cycle. Next state is IDLE.
//  Latency: balance updates at the end of EXEC, i.e. 2 clk after the accepted edge.
//   The display updates BAL_W cycles later. A new request is accepted after BAL_W+2 cycles.
//  day_clr: zeroes wd_total in any state. If it coincides with an EXEC withdrawal, day_clr wins.
//  led flags are sticky until the next accepted IDLE request or reset.
//  Scan:
//   - The refresh counter counts 0..REFRESH_DIV-1. At wrap the index advances and wraps
//     NUM_DIGITS-1 -> 0.
//   - an = ~(1<<index). seg is the decoded digit[index], digit0 = ones.
//   - Leading zeros are displayed.
//  Mid-operation reset: an in-flight transaction is discarded. Everything returns to reset values.
// TESTING (BAL_W=8, NUM_DIGITS=3, WD_LIMIT=120, REFRESH_DIV=4)
//  1. Hold reset low 3 cycles, then release.
//     -> balance=0, led=0, an=3'b110, seg=7'b1000000; an cycles 110,101,011 every 4 clk.
//  2. sw=6'b100000, up edge x2 -> balance=200. Third up edge -> led[1]=1, balance=200.
//  3. Withdraw $100 -> balance=100, wd_total=100.
//     Withdraw $50 -> led[3]=1, balance=100.
//     day_clr, then withdraw $50 -> balance=50, led=0.
//  4. Balance 20, withdraw $50 -> led[2]=1, balance=20.
//     sw=6'b000011 deposit -> led[0]=1.
//     up and down rising in the same cycle -> led[0]=1; neither changes balance.
//  5. Deposit to 205.
//     -> busy high for 9 cycles; display digits 5,0,2 after 8 CONV cycles.
//     -> seg sequence 0010010, 1000000, 0100100.
//     Up edges while busy are ignored.
//  6. Assert reset during CONV of a deposit.
//     -> balance=0, display 000, FSM=IDLE; the next deposit works normally.

Source files
------------

// File: rtl/atm_bank_core.sv
`default_nettype none
// ============================================================================
//  Module   : atm_bank_core
//  Purpose  : Single-account ATM datapath. Rising edges on the deposit and
//             withdraw buttons move the selected bill into or out of a
//             BAL_W-bit balance. Overflow, insufficient funds and daily
//             withdrawal limit violations are rejected and reported on sticky
//             flags. After every transaction the balance is converted to BCD
//             with a multi-cycle shift-add-3 and scanned onto NUM_DIGITS
//             seven-segment digits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1           system clock
//    reset       in   1           synchronous, active-low reset
//    up_btn_i    in   1           deposit request (rising edge acts)
//    down_btn_i  in   1           withdraw request (rising edge acts)
//    day_clr_i   in   1           one-cycle pulse, clears the withdrawal total
//    sw_i        in   6           one-hot bill select $1,$5,$10,$20,$50,$100
//    balance_o   out  BAL_W       current balance
//    busy_o      out  1           high while a transaction executes/converts
//    led_o       out  4           [0] bad request [1] overflow
//                                 [2] insufficient funds [3] limit reached
//    an_o        out  NUM_DIGITS  digit enables, active-low
//    seg_o       out  7           segments g..a, active-low
// ============================================================================
module atm_bank_core #(
  parameter int BAL_W       = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int WD_LIMIT    = 200,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_btn_i,
  input  logic                  down_btn_i,
  input  logic                  day_clr_i,
  input  logic [5:0]            sw_i,
  output logic [BAL_W-1:0]      balance_o,
  output logic                  busy_o,
  output logic [3:0]            led_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o
);

  localparam int c_rw = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cw = $clog2(BAL_W + 1);
  localparam int c_bw = 4 * NUM_DIGITS;
  localparam logic [BAL_W+1:0] c_wd_limit = (BAL_W+2)'(WD_LIMIT);
  localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(BAL_W - 1);
  localparam logic [c_rw-1:0]  c_ref_last = c_rw'(REFRESH_DIV - 1);
  localparam logic [c_iw-1:0]  c_idx_last = c_iw'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CONV = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              up_q, down_q;
  logic              op_q, op_d;            // 1 = withdraw
  logic [BAL_W-1:0]  bill_q, bill_d;
  logic [BAL_W-1:0]  balance_q, balance_d;
  logic [BAL_W:0]    wd_total_q, wd_total_d;
  logic [3:0]        led_q, led_d;
  logic              busy_q, busy_d;
  logic [BAL_W-1:0]  bin_q, bin_d;          // binary snapshot being shifted out
  logic [c_bw-1:0]   work_q, work_d;        // BCD accumulator during CONV
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic [c_bw-1:0]   bcd_q, bcd_d;          // displayed digits
  logic [c_rw-1:0]   ref_q, ref_d;
  logic [c_iw-1:0]   idx_q, idx_d;

  logic              w_up_p, w_down_p;
  logic [BAL_W-1:0]  w_bill;
  logic              w_bill_ok;
  logic [BAL_W:0]    w_dep_sum;
  logic [BAL_W+1:0]  w_wd_sum;
  logic [c_bw-1:0]   w_adj;
  logic [3:0]        w_digit;

  assign w_up_p    = up_btn_i & ~up_q;
  assign w_down_p  = down_btn_i & ~down_q;
  assign w_dep_sum = {1'b0, balance_q} + {1'b0, bill_q};
  assign w_wd_sum  = {1'b0, wd_total_q} + {2'b00, bill_q};

  // Only an exact one-hot selection names a bill; anything else is invalid.
  always_comb begin
    w_bill    = '0;
    w_bill_ok = 1'b1;
    unique case (sw_i)
      6'b000001: w_bill = BAL_W'(1);
      6'b000010: w_bill = BAL_W'(5);
      6'b000100: w_bill = BAL_W'(10);
      6'b001000: w_bill = BAL_W'(20);
      6'b010000: w_bill = BAL_W'(50);
      6'b100000: w_bill = BAL_W'(100);
      default:   w_bill_ok = 1'b0;
    endcase
  end

  // Add-3 correction of every BCD digit before the next shift.
  always_comb begin
    w_adj = work_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bill_d     = bill_q;
    balance_d  = balance_q;
    wd_total_d = wd_total_q;
    led_d      = led_q;
    bin_d      = bin_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;

    unique case (state_q)
      S_IDLE: begin
        if (w_up_p && w_down_p) begin
          led_d = 4'b0001;
        end else if (w_up_p || w_down_p) begin
          led_d  = 4'b0000;
          op_d   = w_down_p;
          bill_d = w_bill;
          if (!w_bill_ok) begin
            led_d[0] = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (!op_q) begin
          if (w_dep_sum[BAL_W]) begin
            led_d[1] = 1'b1;
          end else begin
            balance_d = w_dep_sum[BAL_W-1:0];
          end
        end else if (bill_q > balance_q) begin
          led_d[2] = 1'b1;
        end else if (w_wd_sum > c_wd_limit) begin
          led_d[3] = 1'b1;
        end else begin
          balance_d  = balance_q - bill_q;
          wd_total_d = w_wd_sum[BAL_W:0];
        end
        // Conversion starts from the post-transaction balance.
        bin_d   = balance_d;
        work_d  = '0;
        cnt_d   = '0;
        state_d = S_CONV;
      end

      S_CONV: begin
        work_d = {w_adj[c_bw-2:0], bin_q[BAL_W-1]};
        bin_d  = {bin_q[BAL_W-2:0], 1'b0};
        cnt_d  = cnt_q + c_cw'(1);
        if (cnt_q == c_cnt_last) begin
          bcd_d   = {w_adj[c_bw-2:0], bin_q[BAL_W-1]};
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A day rollover beats a withdrawal committing in the same cycle.
    if (day_clr_i) begin
      wd_total_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Display scan: refresh counter paces the digit index.
  always_comb begin
    ref_d = ref_q + c_rw'(1);
    idx_d = idx_q;
    if (ref_q == c_ref_last) begin
      ref_d = '0;
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_iw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      op_q       <= 1'b0;
      bill_q     <= '0;
      balance_q  <= '0;
      wd_total_q <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ref_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      up_q       <= up_btn_i;
      down_q     <= down_btn_i;
      op_q       <= op_d;
      bill_q     <= bill_d;
      balance_q  <= balance_d;
      wd_total_q <= wd_total_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    w_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == c_iw'(k)) begin
        w_digit = bcd_q[4*k +: 4];
      end
    end
  end

  // Active-low segment patterns, bit 6 = g ... bit 0 = a.
  always_comb begin
    unique case (w_digit)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = 7'b1111111;
    endcase
  end

  assign an_o      = ~(NUM_DIGITS'(1) << idx_q);
  assign balance_o = balance_q;
  assign busy_o    = busy_q;
  assign led_o     = led_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_bank_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atm_bank_core
//  Purpose  : Self-checking bench for atm_bank_core (BAL_W=8, NUM_DIGITS=3,
//             WD_LIMIT=120, REFRESH_DIV=4). Transaction table plus hand-built
//             sequences for timing, display and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_atm_bank_core;

  logic       clk;
  logic       reset;
  logic       up_btn, down_btn, day_clr;
  logic [5:0] sw;
  logic [7:0] balance;
  logic       busy;
  logic [3:0] led;
  logic [2:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [5:0] sw;
    logic       clr;
    logic [7:0] bal;
    logic [3:0] led;
  } vec_t;

  typedef struct {
    logic [7:0] bal;
    logic [3:0] led;
  } exp_t;

  vec_t vt[19];
  exp_t sb[$];

  atm_bank_core #(
    .BAL_W(8), .NUM_DIGITS(3), .WD_LIMIT(120), .REFRESH_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .up_btn_i(up_btn), .down_btn_i(down_btn),
    .day_clr_i(day_clr), .sw_i(sw), .balance_o(balance), .busy_o(busy),
    .led_o(led), .an_o(an), .seg_o(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the settled DUT outputs.
  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got bal %0d expected an entry", name, balance);
    end else begin
      e = sb.pop_front();
      check({name, "_bal"}, 32'(balance), 32'(e.bal));
      check({name, "_led"}, 32'(led), 32'(e.led));
    end
  endtask

  // Wait at negedges for busy to drop; an expired bound counts as a failure.
  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy stuck high, got 1 expected 0", name);
    end
  endtask

  task automatic do_req(input string name, input logic u, input logic d,
                        input logic [5:0] s, input logic clr,
                        input logic [7:0] eb, input logic [3:0] el);
    exp_t e;
    e.bal = eb;
    e.led = el;
    sb.push_back(e);
    @(posedge clk); #1;
    sw = s; up_btn = u; down_btn = d; day_clr = clr;
    @(posedge clk); #1;
    up_btn = 0; down_btn = 0; day_clr = 0;
    wait_idle(name);
    sb_check(name);
  endtask

  // Watch one full scan and compare each digit against its expected pattern.
  task automatic check_scan(input string name, input logic [6:0] s0,
                            input logic [6:0] s1, input logic [6:0] s2);
    int seen0 = 0, seen1 = 0, seen2 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      case (an)
        3'b110: begin seen0++; check({name, "_d0"}, 32'(seg), 32'(s0)); end
        3'b101: begin seen1++; check({name, "_d1"}, 32'(seg), 32'(s1)); end
        3'b011: begin seen2++; check({name, "_d2"}, 32'(seg), 32'(s2)); end
        default: check({name, "_an"}, 32'(an), 32'h6);
      endcase
    end
    check({name, "_seen0"}, 32'(seen0), 32'd4);
    check({name, "_seen1"}, 32'(seen1), 32'd4);
    check({name, "_seen2"}, 32'(seen2), 32'd4);
  endtask

  initial begin
    logic [2:0] exp_an;
    int nbusy;

    //              up dn  sw          clr bal      led
    vt[0]  = '{1'b1, 1'b0, 6'b100000, 1'b0, 8'd100, 4'b0000};
    vt[1]  = '{1'b1, 1'b0, 6'b100000, 1'b0, 8'd200, 4'b0000};
    vt[2]  = '{1'b1, 1'b0, 6'b100000, 1'b0, 8'd200, 4'b0010};
    vt[3]  = '{1'b0, 1'b1, 6'b100000, 1'b0, 8'd100, 4'b0000};
    vt[4]  = '{1'b0, 1'b1, 6'b010000, 1'b0, 8'd100, 4'b1000};
    vt[5]  = '{1'b0, 1'b1, 6'b010000, 1'b1, 8'd50,  4'b0000};
    vt[6]  = '{1'b0, 1'b1, 6'b001000, 1'b0, 8'd30,  4'b0000};
    vt[7]  = '{1'b0, 1'b1, 6'b000100, 1'b0, 8'd20,  4'b0000};
    vt[8]  = '{1'b0, 1'b1, 6'b010000, 1'b0, 8'd20,  4'b0100};
    vt[9]  = '{1'b1, 1'b0, 6'b000011, 1'b0, 8'd20,  4'b0001};
    vt[10] = '{1'b1, 1'b1, 6'b000001, 1'b0, 8'd20,  4'b0001};
    vt[11] = '{1'b1, 1'b0, 6'b000000, 1'b0, 8'd20,  4'b0001};
    vt[12] = '{1'b0, 1'b1, 6'b001000, 1'b0, 8'd0,   4'b0000};
    vt[13] = '{1'b1, 1'b0, 6'b001000, 1'b0, 8'd20,  4'b0000};
    vt[14] = '{1'b0, 1'b1, 6'b001000, 1'b0, 8'd0,   4'b0000};
    vt[15] = '{1'b1, 1'b0, 6'b000001, 1'b0, 8'd1,   4'b0000};
    vt[16] = '{1'b0, 1'b1, 6'b000001, 1'b0, 8'd1,   4'b1000};
    vt[17] = '{1'b1, 1'b0, 6'b000010, 1'b1, 8'd6,   4'b0000};
    vt[18] = '{1'b0, 1'b1, 6'b000010, 1'b0, 8'd1,   4'b0000};

    reset = 0; up_btn = 0; down_btn = 0; day_clr = 0; sw = 6'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // Reset state and scan order: each digit held for 4 clocks.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("rst_bal",  32'(balance), 32'd0);
        check("rst_led",  32'(led),     32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_seg",  32'(seg),     32'b1000000);
      end
      case ((k / 4) % 3)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        default: exp_an = 3'b011;
      endcase
      check($sformatf("scan_an%0d", k), 32'(an), 32'(exp_an));
    end

    for (int i = 0; i < 19; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].up, vt[i].dn, vt[i].sw, vt[i].clr,
             vt[i].bal, vt[i].led);
    end

    // Fresh start, build 200 then deposit $5 with timing and display checks.
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    do_req("dep100a", 1'b1, 1'b0, 6'b100000, 1'b0, 8'd100, 4'b0000);
    do_req("dep100b", 1'b1, 1'b0, 6'b100000, 1'b0, 8'd200, 4'b0000);

    begin
      exp_t e;
      e.bal = 8'd205;
      e.led = 4'b0000;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    sw = 6'b000010; up_btn = 1;
    @(posedge clk); #1;
    up_btn = 0;
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) check("lat_exec_bal", 32'(balance), 32'd200);
      if (i == 1) check("lat_done_bal", 32'(balance), 32'd205);
      if (i == 3) up_btn = 1;   // edge while busy must be ignored
      if (i == 4) up_btn = 0;
      if (busy) nbusy++;
      else break;
    end
    check("busy_len", 32'(nbusy), 32'd9);
    sb_check("dep5");
    check_scan("disp205", 7'b0010010, 7'b1000000, 7'b0100100);

    // Overflow boundary: exactly 255 is allowed, one more is not.
    do_req("to255", 1'b1, 1'b0, 6'b010000, 1'b0, 8'd255, 4'b0000);
    do_req("ovf1",  1'b1, 1'b0, 6'b000001, 1'b0, 8'd255, 4'b0010);

    // Reset in the middle of CONV discards everything.
    @(posedge clk); #1;
    sw = 6'b100000; up_btn = 1;
    @(posedge clk); #1;
    up_btn = 0;
    repeat (4) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("mrst_bal",  32'(balance), 32'd0);
    check("mrst_led",  32'(led),     32'd0);
    check("mrst_busy", 32'(busy),    32'd0);
    check("mrst_an",   32'(an),      32'b110);
    check("mrst_seg",  32'(seg),     32'b1000000);
    do_req("post_rst", 1'b1, 1'b0, 6'b000100, 1'b0, 8'd10, 4'b0000);
    check_scan("disp010", 7'b1000000, 7'b1111001, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
